fetch_decode_buffer: RTL and testbench

Receiving end of the Fetch stage output interface. Accepts instruction/pc/next_pc bundles from Fetch and buffers them in a small FIFO. Presents them to Decode with valid/stall handshaking. Back-pressures Fetch when full. Flushes all wrong-path entries when Execute redirects the PC.

---
 rtl/riscv_pipe_pkg.sv | 15 +
 rtl/fetch_bundle_fifo_mem.sv | 28 ++
 rtl/fetch_decode_buffer.sv | 120 ++++++++++++
 tb/tb_fetch_decode_buffer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Types and constants shared by the RISC-V pipeline stages.
// Defines the Fetch-to-Decode bundle and the canonical NOP encoding.
package riscv_pipe_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
  } fetch_bundle_t;

endpackage

// File: rtl/fetch_bundle_fifo_mem.sv
// Bundle storage for the fetch/decode buffer.
// One synchronous write port and one asynchronous read port.
module fetch_bundle_fifo_mem
  import riscv_pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  fetch_bundle_t wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output fetch_bundle_t rd_data_o
);

  // Contents are don't-care out of reset, so no reset term.
  fetch_bundle_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fetch_decode_buffer.sv
// Fetch-to-Decode FIFO with back-pressure and redirect flush.
// Define FETCH_DECODE_BYPASS_EN for a same-cycle path when empty.
module fetch_decode_buffer
  import riscv_pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [XLEN-1:0]        instruction_fetch,
  input  logic [XLEN-1:0]        pc_fetch,
  input  logic [XLEN-1:0]        next_pc_fetch,
  input  logic                   valid_fetch,
  output logic                   stall_fetch,
  input  logic                   pc_select_execute,
  input  logic                   stall_decode,
  output logic [XLEN-1:0]        instruction_decode,
  output logic [XLEN-1:0]        pc_decode,
  output logic [XLEN-1:0]        next_pc_decode,
  output logic                   valid_decode,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  fetch_bundle_t fetch_b;
  fetch_bundle_t mem_b;
  fetch_bundle_t head_b;

  logic empty;
  logic full;
  logic byp;
  logic push;
  logic pop;
  logic wr_en;
  logic rd_adv;

  assign fetch_b.instr   = instruction_fetch;
  assign fetch_b.pc      = pc_fetch;
  assign fetch_b.next_pc = next_pc_fetch;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

`ifdef FETCH_DECODE_BYPASS_EN
  assign byp = empty & valid_fetch;
`else
  assign byp = 1'b0;
`endif

  assign stall_fetch  = full;
  assign valid_decode = (~empty | byp) & ~pc_select_execute;
  assign head_b       = byp ? fetch_b : mem_b;

  assign push = valid_fetch & ~full & ~pc_select_execute;
  assign pop  = valid_decode & ~stall_decode;

  // A bypassed bundle that Decode takes never touches storage.
  assign wr_en  = push & ~(byp & pop);
  assign rd_adv = pop & ~byp;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pc_select_execute) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_adv) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({wr_en, rd_adv})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_bundle_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (fetch_b),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (mem_b)
  );

  assign instruction_decode = valid_decode ? head_b.instr : NOP_INSTR;
  assign pc_decode          = valid_decode ? head_b.pc : '0;
  assign next_pc_decode     = valid_decode ? head_b.next_pc : '0;
  assign occupancy          = count_q;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Randomized and directed bench for fetch_decode_buffer.
// Reference model is a queue of bundles.
module tb_fetch_decode_buffer;
  import riscv_pipe_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int VW    = 98 + CW;
`ifdef FETCH_DECODE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   instr_f, pc_f, npc_f;
  logic          vf, pcsel, sd;
  logic          stall_fetch, valid_decode;
  logic [31:0]   instruction_decode, pc_decode, next_pc_decode;
  logic [CW-1:0] occupancy;

  fetch_bundle_t q[$];
  int checks   = 0;
  int failures = 0;
  bit acc;

  wire [VW-1:0] act = {valid_decode, instruction_decode, pc_decode,
                       next_pc_decode, occupancy, stall_fetch};
  wire [VW-1:0] rst_vec = {1'b0, NOP_INSTR, 32'h0, 32'h0, {CW{1'b0}}, 1'b0};

  fetch_decode_buffer #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .instruction_fetch  (instr_f),
    .pc_fetch           (pc_f),
    .next_pc_fetch      (npc_f),
    .valid_fetch        (vf),
    .stall_fetch        (stall_fetch),
    .pc_select_execute  (pcsel),
    .stall_decode       (sd),
    .instruction_decode (instruction_decode),
    .pc_decode          (pc_decode),
    .next_pc_decode     (next_pc_decode),
    .valid_decode       (valid_decode),
    .occupancy          (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] expv();
    bit byp, ev;
    logic [31:0] ei, ep, en;
    byp = BYP && q.size() == 0 && vf;
    ev  = (q.size() != 0 || byp) && !pcsel;
    ei = NOP_INSTR; ep = 0; en = 0;
    if (ev && byp) begin
      ei = instr_f; ep = pc_f; en = npc_f;
    end else if (ev) begin
      ei = q[0].instr; ep = q[0].pc; en = q[0].next_pc;
    end
    return {ev, ei, ep, en, CW'(q.size()), q.size() == DEPTH};
  endfunction

  task automatic model_edge();
    bit byp, pop;
    fetch_bundle_t b;
    acc = 0;
    if (pcsel) begin
      q.delete();
      return;
    end
    byp = BYP && q.size() == 0 && vf;
    pop = (q.size() != 0 || byp) && !sd;
    if (byp && pop) begin
      acc = 1;
      return;
    end
    acc = vf && q.size() < DEPTH;
    b.instr = instr_f; b.pc = pc_f; b.next_pc = npc_f;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(b);
  endtask

  task automatic drive(input bit v, input logic [31:0] ins,
                       input logic [31:0] p, input bit ps, input bit s);
    vf = v; instr_f = ins; pc_f = p; npc_f = p + 32'd4;
    pcsel = ps; sd = s;
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #2;
    checks++;
    if (act !== rst_vec) begin
      failures++;
      $display("FAIL reset act=%h exp=%h", act, rst_vec);
    end
    @(negedge clk) rst = 1'b0;
    advance();
  endtask

  task automatic test_in_order();
    logic [31:0] ins [3];
    logic [VW-1:0] e;
    ins[0] = 32'h00500093; ins[1] = 32'h00100113; ins[2] = 32'h002081B3;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive(1, ins[i], 32'(i * 4), 0, 0);
      else drive(0, 0, 0, 0, 0);
      @(negedge clk);
      e = expv();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL in_order c%0d act=%h exp=%h", i, act, e);
      end
      checks++;
      if (occupancy > 1) begin
        failures++;
        $display("FAIL in_order_occ c%0d act=%0d exp<=1", i, occupancy);
      end
      advance();
    end
  endtask

  task automatic test_full();
    logic [VW-1:0] e;
    int k = 0;
    for (int c = 0; c < 14; c++) begin
      drive(k < 5, 32'h00000093 + 32'(k << 20), 32'(k * 4), 0, c < 6);
      @(negedge clk);
      e = expv();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL full c%0d act=%h exp=%h", c, act, e);
      end
      if (c == 4) begin
        checks++;
        if ({occupancy, stall_fetch} !== {CW'(4), 1'b1}) begin
          failures++;
          $display("FAIL full_flag act=%0d/%b exp=4/1", occupancy, stall_fetch);
        end
      end
      advance();
      if (acc) k++;
    end
  endtask

  task automatic test_flush();
    logic [VW-1:0] e;
    for (int c = 0; c < 8; c++) begin
      unique case (c)
        0, 1, 2: drive(1, 32'h13 + 32'(c), 32'h10 + 32'(4 * c), 0, 1);
        3:       drive(1, 32'hDEAD0013, 32'h1C, 1, 0);
        5:       drive(1, 32'h00000513, 32'h40, 0, 0);
        default: drive(0, 0, 0, 0, 0);
      endcase
      @(negedge clk);
      e = expv();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL flush c%0d act=%h exp=%h", c, act, e);
      end
      if (c == 3 || c == 4) begin
        checks++;
        if (valid_decode !== 1'b0 || (c == 4 && occupancy !== '0)) begin
          failures++;
          $display("FAIL flush_kill c%0d act=%b/%0d exp=0", c, valid_decode, occupancy);
        end
      end
      if (c == 6) begin
        checks++;
        if ({valid_decode, pc_decode} !== {1'b1, 32'h40}) begin
          failures++;
          $display("FAIL flush_next act=%b/%h exp=1/40", valid_decode, pc_decode);
        end
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] e;
    for (int c = 0; c < 15; c++) begin
      drive(c < 12, 32'h00A00013 + 32'(c), 32'h300 + 32'(4 * c), 0, c < 2);
      @(negedge clk);
      e = expv();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL b2b c%0d act=%h exp=%h", c, act, e);
      end
      if (c >= 2 && c < 12) begin
        checks++;
        if (occupancy !== CW'(2)) begin
          failures++;
          $display("FAIL b2b_occ c%0d act=%0d exp=2", c, occupancy);
        end
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1, 32'h00200013, 32'h500 + 32'(4 * c), 0, 1);
      advance();
    end
    drive(0, 0, 0, 0, 1);
    checks++;
    if (occupancy !== CW'(3)) begin
      failures++;
      $display("FAIL arst_pre act=%0d exp=3", occupancy);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (act !== rst_vec) begin
      failures++;
      $display("FAIL arst act=%h exp=%h", act, rst_vec);
    end
    q.delete();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

`ifdef FETCH_DECODE_BYPASS_EN
  task automatic test_bypass();
    drive(1, 32'h00700013, 32'h100, 0, 0);
    @(negedge clk);
    checks++;
    if ({valid_decode, pc_decode, occupancy} !== {1'b1, 32'h100, CW'(0)}) begin
      failures++;
      $display("FAIL byp_same act=%b/%h/%0d exp=1/100/0", valid_decode, pc_decode, occupancy);
    end
    advance();
    drive(1, 32'h00700013, 32'h100, 0, 1);
    checks++;
    if (occupancy !== CW'(0)) begin
      failures++;
      $display("FAIL byp_consumed act=%0d exp=0", occupancy);
    end
    @(negedge clk);
    checks++;
    if ({valid_decode, pc_decode} !== {1'b1, 32'h100}) begin
      failures++;
      $display("FAIL byp_stall act=%b/%h exp=1/100", valid_decode, pc_decode);
    end
    advance();
    checks++;
    if (occupancy !== CW'(1)) begin
      failures++;
      $display("FAIL byp_written act=%0d exp=1", occupancy);
    end
    drive(0, 0, 0, 0, 0);
    advance();
  endtask
`endif

  task automatic test_random();
    logic [VW-1:0] e;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom(), {$urandom_range(0, 1023), 2'b00},
            $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
      @(negedge clk);
      e = expv();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL random c%0d act=%h exp=%h", c, act, e);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full();
    test_flush();
    test_back_to_back();
    test_async_reset();
`ifdef FETCH_DECODE_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
